// File: rtl/clic_nest_arbiter_pkg.sv
// Shared defaults and the threshold-stack operation encoding for the nesting CLIC arbiter.
package clic_nest_arbiter_pkg;

  localparam int N_IRQ_DEF  = 8;
  localparam int PRIO_W_DEF = 3;
  localparam int DEPTH_DEF  = 4;

  // One operation per cycle on the threshold/stack; a take outranks a plain return or a direct write.
  typedef enum logic [2:0] {
    THR_HOLD,
    THR_PUSH,
    THR_POP,
    THR_CHAIN,
    THR_WRITE
  } thr_op_e;

endpackage

// File: rtl/clic_max_tree.sv
// Combinational max-priority search over the candidate lines; equal priorities resolve to the higher index.
module clic_max_tree
  import clic_nest_arbiter_pkg::*;
#(
  parameter int N      = N_IRQ_DEF,
  parameter int PRIO_W = PRIO_W_DEF
) (
  input  logic [N-1:0]         cand,
  input  logic [PRIO_W-1:0]    prio [N],
  output logic                 found,
  output logic [$clog2(N)-1:0] id,
  output logic [PRIO_W-1:0]    best_prio
);

  localparam int IW = $clog2(N);

  // Scanning upward with >= lets a later (higher) index win a tie.
  always_comb begin
    found     = 1'b0;
    id        = '0;
    best_prio = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && (!found || prio[i] >= best_prio)) begin
        found     = 1'b1;
        id        = IW'(i);
        best_prio = prio[i];
      end
    end
  end

endmodule

// File: rtl/clic_nest_arbiter.sv
// CLIC core: per-line config, level/edge pending capture, thresholded arbitration with a
// valid/ready offer, and a threshold stack that lets higher-priority lines pre-empt a handler.
module clic_nest_arbiter
  import clic_nest_arbiter_pkg::*;
#(
  parameter int N_IRQ  = N_IRQ_DEF,
  parameter int PRIO_W = PRIO_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IRQ-1:0]           irq_i,
  input  logic                       cfg_we_i,
  input  logic [$clog2(N_IRQ)-1:0]   cfg_idx_i,
  input  logic [PRIO_W-1:0]          cfg_prio_i,
  input  logic                       cfg_en_i,
  input  logic                       cfg_edge_i,
  input  logic                       thr_we_i,
  input  logic [PRIO_W-1:0]          thr_i,
  output logic                       irq_valid_o,
  output logic [$clog2(N_IRQ)-1:0]   irq_id_o,
  output logic [PRIO_W-1:0]          irq_prio_o,
  input  logic                       irq_ready_i,
  input  logic                       ret_i,
  output logic [PRIO_W-1:0]          thr_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o
);

  localparam int IW = $clog2(N_IRQ);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PRIO_W-1:0] prio_t;
  typedef logic [IW-1:0]     index_t;
  typedef struct packed {
    prio_t prio;
    logic  en;
    logic  edge_mode;
  } cfg_t;

  cfg_t             cfg_q [N_IRQ];
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] irq_q;
  prio_t            thr_q;
  logic [DW-1:0]    depth_q;
  prio_t            stack_q [DEPTH];
  logic             valid_q;
  index_t           id_q;
  prio_t            prio_q;

  logic [N_IRQ-1:0] cand;
  prio_t            prio_vec [N_IRQ];
  logic             win_found;
  index_t           win_id;
  prio_t            win_prio;
  logic             take;
  logic             do_ret;
  logic             offer;
  thr_op_e          thr_op;
  logic [SW-1:0]    push_idx;
  logic [SW-1:0]    pop_idx;

  always_comb begin
    cand = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      cand[i]     = pending_q[i] & cfg_q[i].en;
      prio_vec[i] = cfg_q[i].prio;
    end
  end

  clic_max_tree #(
    .N      (N_IRQ),
    .PRIO_W (PRIO_W)
  ) u_max_tree (
    .cand      (cand),
    .prio      (prio_vec),
    .found     (win_found),
    .id        (win_id),
    .best_prio (win_prio)
  );

  assign take     = valid_q & irq_ready_i;
  assign do_ret   = ret_i & (depth_q != '0);
  assign offer    = win_found && (win_prio > thr_q) && (depth_q < DW'(DEPTH));
  assign push_idx = SW'(depth_q);
  assign pop_idx  = SW'(depth_q - DW'(1));

  always_comb begin
    thr_op = THR_HOLD;
    if (take && do_ret)  thr_op = THR_CHAIN;
    else if (take)       thr_op = THR_PUSH;
    else if (do_ret)     thr_op = THR_POP;
    else if (thr_we_i)   thr_op = THR_WRITE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IRQ; i++) cfg_q[i] <= '0;
    end else if (cfg_we_i) begin
      cfg_q[cfg_idx_i] <= '{prio: cfg_prio_i, en: cfg_en_i, edge_mode: cfg_edge_i};
    end
  end

  // Edge lines keep their bit until the core takes that id; a new edge in the take cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      irq_q     <= '0;
    end else begin
      irq_q <= irq_i;
      for (int i = 0; i < N_IRQ; i++) begin
        if (cfg_q[i].edge_mode)
          pending_q[i] <= (irq_i[i] & ~irq_q[i]) |
                          (pending_q[i] & ~(take && (id_q == IW'(i))));
        else
          pending_q[i] <= irq_i[i];
      end
    end
  end

  // The offer in flight during a take was computed against the old threshold, so it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      prio_q  <= '0;
    end else begin
      valid_q <= offer & ~take;
      if (offer && !take) begin
        id_q   <= win_id;
        prio_q <= win_prio;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q   <= '0;
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      case (thr_op)
        THR_PUSH: begin
          stack_q[push_idx] <= thr_q;
          thr_q             <= prio_q;
          depth_q           <= depth_q + DW'(1);
        end
        THR_POP: begin
          thr_q   <= stack_q[pop_idx];
          depth_q <= depth_q - DW'(1);
        end
        THR_CHAIN: thr_q <= prio_q;
        THR_WRITE: thr_q <= thr_i;
        default:   ;
      endcase
    end
  end

  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign irq_prio_o  = prio_q;
  assign thr_o       = thr_q;
  assign depth_o     = depth_q;

endmodule
